// File: rtl/wrr_pkg.sv
// ============================================================================
// Module : wrr_pkg
// Brief  : Shared types and round-robin pick helpers for the arbiter family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wrr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_N = 32;
  localparam int IDXW  = $clog2(MAX_N);

  // First set bit of req at or after ptr, wrapping modulo n; same result as
  // rotate-right / isolate-lowest / rotate-left, without variable shifters.
  function automatic logic [MAX_N-1:0] rr_onehot(input logic [MAX_N-1:0] req,
                                                 input int ptr,
                                                 input int n);
    logic [MAX_N-1:0] pick;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (!found && req[j[IDXW-1:0]]) begin
          pick[j[IDXW-1:0]] = 1'b1;
          found             = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [IDXW-1:0] oh2idx(input logic [MAX_N-1:0] oh);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | i[IDXW-1:0];
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotating-priority pick: one-hot winner and its index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import wrr_pkg::*;
#(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [M-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [M-1:0] idx
);

  logic [MAX_N-1:0] req_ext;
  logic [MAX_N-1:0] gnt_ext;
  logic [IDXW-1:0]  idx_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    gnt_ext        = rr_onehot(req_ext, 32'(ptr), N);
    idx_ext        = oh2idx(gnt_ext);
  end

  assign gnt = gnt_ext[N-1:0];
  assign idx = idx_ext[M-1:0];

  generate
    if (N < MAX_N) begin : g_pad_sink
      logic unused_pad;
      assign unused_pad = ^{gnt_ext[MAX_N-1:N], idx_ext};
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/wrr_burst_arbiter.sv
// ============================================================================
// Module : wrr_burst_arbiter
// Brief  : Weighted round-robin burst arbiter; grants last up to weight[i]
//          beats. Define WRR_TIMEOUT_EN to add the idle-beat watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wrr_burst_arbiter
  import wrr_pkg::*;
#(
  parameter  int N              = 8,
  parameter  int W              = 4,
  parameter  int DEFAULT_WEIGHT = 1,
  parameter  int TIMEOUT        = 16,
  localparam int M              = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [N-1:0] i_req,
  input  logic         i_beat,
  input  logic         i_last,
  input  logic         i_cfg_we,
  input  logic [M-1:0] i_cfg_idx,
  input  logic [W-1:0] i_cfg_weight,
`ifdef WRR_TIMEOUT_EN
  output logic         o_timeout,
`endif
  output logic [N-1:0] o_gnt,
  output logic         o_gnt_vld,
  output logic [M-1:0] o_gnt_idx,
  output logic [W-1:0] o_credit
);

  state_t       state_q, state_d;
  logic [M-1:0] ptr_q, ptr_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [M-1:0] idx_q, idx_d;
  logic [W-1:0] credit_q, credit_d;
  logic [W-1:0] weight_q [N];
  logic [W-1:0] weight_d [N];

  logic [N-1:0] elig;
  logic [N-1:0] pick_gnt;
  logic [M-1:0] pick_idx;
  logic         owner_req;
  logic         timeout_hit;
  logic         release_now;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = i_req[i] && (weight_q[i] != '0);
    end
  end

  rr_pick #(.N(N), .M(M)) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign owner_req = |(i_req & gnt_q);

`ifdef WRR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout_q;

  // Fires on the cycle whose missing beat would bring the count to TIMEOUT.
  assign timeout_hit = (state_q == GRANT) && !i_beat && (tcnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    tcnt_d = '0;
    if (state_q == GRANT && !release_now && !i_beat) tcnt_d = tcnt_q + TW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_hit;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_now = (state_q == GRANT) &&
                       ((i_beat && (credit_q == W'(1) || i_last)) || !owner_req || timeout_hit);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      weight_d[i] = weight_q[i];
      if (i_cfg_we && (i_cfg_idx == i[M-1:0])) weight_d[i] = i_cfg_weight;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      credit_q <= '0;
      for (int i = 0; i < N; i++) weight_q[i] <= W'(DEFAULT_WEIGHT);
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      credit_q <= credit_d;
      for (int i = 0; i < N; i++) weight_q[i] <= weight_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|elig)      state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        idx_d    = '0;
        credit_d = '0;
        if (|elig) begin
          gnt_d    = pick_gnt;
          idx_d    = pick_idx;
          credit_d = weight_q[pick_idx];
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d    = '0;
          idx_d    = '0;
          credit_d = '0;
          ptr_d    = (idx_q == M'(N - 1)) ? '0 : idx_q + M'(1);
        end else if (i_beat) begin
          credit_d = credit_q - W'(1);
        end
      end
      default: begin
        gnt_d    = '0;
        idx_d    = '0;
        credit_d = '0;
      end
    endcase
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_vld = |gnt_q;
  assign o_gnt_idx = idx_q;
  assign o_credit  = credit_q;

endmodule

`default_nettype wire

// File: tb/tb_wrr_burst_arbiter.sv
// ============================================================================
// Module : tb_wrr_burst_arbiter
// Brief  : Directed self-checking bench for wrr_burst_arbiter (default build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wrr_burst_arbiter;

  localparam int N = 8;
  localparam int W = 4;
  localparam int M = 3;

  logic         clk;
  logic         rstn;
  logic [N-1:0] req;
  logic         beat;
  logic         last;
  logic         cfg_we;
  logic [M-1:0] cfg_idx;
  logic [W-1:0] cfg_weight;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [M-1:0] gnt_idx;
  logic [W-1:0] credit;

  int n_tests = 0;
  int n_fail  = 0;

  wrr_burst_arbiter #(
    .N(N), .W(W), .DEFAULT_WEIGHT(1), .TIMEOUT(16)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req        (req),
    .i_beat       (beat),
    .i_last       (last),
    .i_cfg_we     (cfg_we),
    .i_cfg_idx    (cfg_idx),
    .i_cfg_weight (cfg_weight),
    .o_gnt        (gnt),
    .o_gnt_vld    (gnt_vld),
    .o_gnt_idx    (gnt_idx),
    .o_credit     (credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req    = '0;
    beat   = 1'b0;
    last   = 1'b0;
    cfg_we = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic cfg_write(input logic [M-1:0] idx, input logic [W-1:0] w);
    cfg_we     = 1'b1;
    cfg_idx    = idx;
    cfg_weight = w;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic chk_grant(input string tag, input int vld, input int idx, input int cr);
    chk({tag, "_vld"}, 32'(gnt_vld), 32'(vld));
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, "_cr"},  32'(credit),  32'(cr));
    chk({tag, "_gnt"}, 32'(gnt), vld != 0 ? (32'd1 << idx) : 32'd0);
  endtask

  // Expected grant trace for the two-requester alternation, weights all 1.
  logic [7:0] t1_gnt [6] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
  // Weighted trace: weight[2]=3, weight[5]=1.
  int t2_vld [7] = '{1, 1, 1, 0, 1, 0, 1};
  int t2_idx [7] = '{2, 2, 2, 0, 5, 0, 2};
  int t2_cr  [7] = '{3, 2, 1, 0, 1, 0, 3};

  initial begin
    cfg_idx    = '0;
    cfg_weight = '0;
    do_reset();
    chk_grant("reset", 0, 0, 0);

    // Alternation 0 / 7 with wrap of the pointer.
    req  = 8'b1000_0001;
    beat = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("alt_gnt%0d", i), 32'(gnt), 32'(t1_gnt[i]));
    end

    // Weighted burst.
    do_reset();
    cfg_write(3'd2, 4'd3);
    cfg_write(3'd5, 4'd1);
    req  = 8'h24;
    beat = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_grant($sformatf("wt%0d", i), t2_vld[i], t2_idx[i], t2_cr[i]);
    end

    // Early release by i_last on the second beat.
    do_reset();
    cfg_write(3'd4, 4'd4);
    req  = 8'h30;
    beat = 1'b1;
    tick();
    chk_grant("last_b1", 1, 4, 4);
    tick();
    chk_grant("last_b2", 1, 4, 3);
    last = 1'b1;
    tick();
    last = 1'b0;
    chk_grant("last_bub", 0, 0, 0);
    tick();
    chk_grant("last_next", 1, 5, 1);

    // Withdrawal mid-grant, then a weight-0 requester alone.
    do_reset();
    cfg_write(3'd3, 4'd5);
    req  = 8'h08;
    beat = 1'b0;
    tick();
    chk_grant("wd_g0", 1, 3, 5);
    tick();
    chk_grant("wd_g1", 1, 3, 5);
    req = 8'h00;
    tick();
    chk_grant("wd_rel", 0, 0, 0);
    cfg_write(3'd6, 4'd0);
    req = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mask_vld%0d", i), 32'(gnt_vld), 32'd0);
    end

    // Weight write during the owner's grant, then async reset mid-grant.
    do_reset();
    cfg_write(3'd1, 4'd2);
    req  = 8'h02;
    beat = 1'b1;
    tick();
    chk_grant("cfg_g0", 1, 1, 2);
    cfg_we     = 1'b1;
    cfg_idx    = 3'd1;
    cfg_weight = 4'd7;
    tick();
    cfg_we = 1'b0;
    chk_grant("cfg_g1", 1, 1, 1);
    tick();
    chk_grant("cfg_bub", 0, 0, 0);
    tick();
    chk_grant("cfg_new", 1, 1, 7);
    rstn = 1'b0;
    #1;
    chk_grant("async_rst", 0, 0, 0);
    rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
